// File: rtl/spi_cmd_deframer.sv
// -----------------------------------------------------------------------------
// spi_cmd_deframer
//
// Deserialises fixed-width command frames arriving on the cs-gated MOSI line
// into ALU operands (op_code, a, b), presents them with a valid/ack handshake,
// and returns the previous ALU result serially on MISO during the next frame.
//
// Frame layout (MSB first): [9:8] op_code, [7:4] a, [3:0] b.
//
// Optional build macro SPI_CMD_PARITY_EN: each frame carries one extra trailing
// bit of even parity over the command bits. A parity mismatch drops the frame
// and pulses frame_err on the parity-bit edge.
//
// Ports:
//   clk        design clock, all inputs sampled on its rising edge
//   rst        asynchronous reset, active-high
//   cs         chip select, active-low
//   mosi       serial command data in, MSB first
//   result     ALU result returned on miso, sampled at frame start
//   miso       serial result out, MSB first (registered)
//   a, b       decoded operands
//   op_code    decoded ALU operation
//   cmd_valid  command registers hold an unconsumed command
//   cmd_ack    consumer accepts the current command
//   busy       a frame is in progress
//   frame_err  one-cycle pulse on an aborted or bad frame
//   overrun    sticky: a completed frame was dropped because cmd_valid was set
// -----------------------------------------------------------------------------
module spi_cmd_deframer #(
   parameter int FRAME_W = 10,
   parameter int RES_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cs,
   input  logic             mosi,
   input  logic [RES_W-1:0] result,
   output logic             miso,
   output logic [3:0]       a,
   output logic [3:0]       b,
   output logic [1:0]       op_code,
   output logic             cmd_valid,
   input  logic             cmd_ack,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

`ifdef SPI_CMD_PARITY_EN
   localparam int LEN = FRAME_W + 1;
`else
   localparam int LEN = FRAME_W;
`endif
   localparam int CNT_W = $clog2(LEN + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   bit_cnt;
   logic [LEN-1:0]     rx_sr;
   logic [RES_W-1:0]   tx_sr;

   logic [LEN-1:0]     frame_bits;   // shift register with the current bit appended
   logic [FRAME_W-1:0] cmd_bits;
   logic               last_bit;
   logic               frame_done;
   logic               abort;
   logic               par_fail;
   logic               frame_ok;
   logic               load_cmd;
   logic               flag_overrun;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and frame-event decode
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      abort      = 1'b0;
      frame_bits = {rx_sr[LEN-2:0], mosi};
      cmd_bits   = frame_bits[LEN-1 -: FRAME_W];
      last_bit   = (bit_cnt == CNT_W'(LEN - 1));

      case (state)
         IDLE: begin
            if (!cs) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (cs) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end else if (last_bit) begin
               frame_done = 1'b1;
               state_nxt  = HOLD;
            end
         end
         HOLD: begin
            if (cs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

`ifdef SPI_CMD_PARITY_EN
      // Even parity: the trailing bit must equal the XOR of the command bits.
      par_fail = frame_done && (frame_bits[0] != ^cmd_bits);
`else
      par_fail = 1'b0;
`endif
      frame_ok = frame_done && !par_fail;
      // An ack on the completion edge frees the slot for the new command.
      load_cmd     = frame_ok && (!cmd_valid || cmd_ack);
      flag_overrun = frame_ok && cmd_valid && !cmd_ack;
   end

   assign busy = (state != IDLE);

   // Shift registers, miso, command registers and flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt   <= '0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         miso      <= 1'b0;
         a         <= '0;
         b         <= '0;
         op_code   <= '0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= abort | par_fail;

         case (state)
            IDLE: begin
               if (!cs) begin
                  // First bit: result MSB goes out immediately, the rest queue up.
                  rx_sr   <= {{(LEN-1){1'b0}}, mosi};
                  bit_cnt <= CNT_W'(1);
                  miso    <= result[RES_W-1];
                  tx_sr   <= result << 1;
               end else begin
                  miso <= 1'b0;
               end
            end
            SHIFT: begin
               if (cs) begin
                  rx_sr   <= '0;
                  bit_cnt <= '0;
                  tx_sr   <= '0;
                  miso    <= 1'b0;
               end else begin
                  rx_sr   <= frame_bits;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  miso    <= tx_sr[RES_W-1];
                  tx_sr   <= tx_sr << 1;
               end
            end
            HOLD: begin
               miso  <= 1'b0;
               tx_sr <= '0;
               if (cs) bit_cnt <= '0;
            end
            default: begin
               miso <= 1'b0;
            end
         endcase

         if (load_cmd) begin
            op_code   <= cmd_bits[FRAME_W-1 -: 2];
            a         <= cmd_bits[7:4];
            b         <= cmd_bits[3:0];
            cmd_valid <= 1'b1;
         end else if (cmd_ack) begin
            cmd_valid <= 1'b0;
         end

         if (flag_overrun) overrun <= 1'b1;
      end
   end

endmodule

// File: doc/spi_cmd_deframer.md
Name: spi_cmd_deframer

Overview:
- Sits directly downstream of the SPI slave input path (cs-gated MOSI) and upstream of the ALU / PWM / seven-segment consumers.
- Deserialises fixed-width command frames from MOSI into ALU operands a, b and op_code.
- Presents each command with a valid/ack handshake.
- Serially returns the last ALU result on MISO during the next frame.

Parameters:
- FRAME_W, 10, command bits per frame (op_code 2 + a 4 + b 4).
- RES_W, 5, result bits returned on MISO ({carry_out, out[3:0]}).

Ports:
- clk  input  1  single design clock; all inputs are sampled on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- cs  input  1  chip select, active-low.
- mosi  input  1  serial data in, MSB first.
- result  input  RES_W  ALU result to return; sampled at frame start.
- miso  output  1  serial data out, MSB first.
- a  output  4  operand A.
- b  output  4  operand B.
- op_code  output  2  ALU operation.
- cmd_valid  output  1  command registers hold an unconsumed command.
- cmd_ack  input  1  consumer accepts the command.
- busy  output  1  frame in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse on an aborted or bad frame.
- overrun  output  1  sticky flag: a completed frame was dropped.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit_cnt=0, rx_sr=0, tx_sr=0, a=b=op_code=0, cmd_valid=0, miso=0, busy=0, frame_err=0, overrun=0. Reset asserted mid-frame discards the frame immediately.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - miso=0.
  - On a rising edge with cs=0: rx_sr captures mosi as bit FRAME_W-1, bit_cnt=1, tx_sr loads result, next state SHIFT.
- SHIFT:
  - Each edge with cs=0: rx_sr shifts left with mosi in the LSB, bit_cnt++, tx_sr shifts left with 0 in.
  - When the FRAME_W-th bit is captured, the frame is complete. Go to HOLD.
- Frame decode (MSB first): frame[9:8]=op_code, [7:4]=a, [3:0]=b.
- Completion update: a, b, op_code and cmd_valid update on the edge that captures the last bit. Latency is 0 cycles after the last bit edge; the outputs are visible the following cycle.
- miso:
  - Driven from tx_sr[RES_W-1] (registered).
  - result[RES_W-1] appears in the cycle after the first sampling edge; one bit per cycle follows.
  - After RES_W bits, miso=0 until the frame ends.
- HOLD:
  - Extra bits while cs=0 are ignored; miso=0.
  - cs=1 goes to IDLE.
- Abort: cs=1 in SHIFT before FRAME_W bits have been captured. Discard rx_sr, frame_err=1 for one cycle, go to IDLE. Command registers and cmd_valid are unchanged.
- Handshake:
  - cmd_valid rises on completion and stays high until a cycle with cmd_ack=1; it clears on that edge.
  - cmd_ack while cmd_valid=0 has no effect.
  - a, b and op_code stay stable while cmd_valid=1.
- Overrun:
  - Frame completes while cmd_valid=1 and cmd_ack=0: the new frame is dropped, overrun=1 (sticky until rst), and the command registers are unchanged.
  - Completion with cmd_ack=1 on the same edge: the new command is loaded and cmd_valid stays 1.
- Back-to-back frames: cs=1 for a single cycle between frames is sufficient. The next cs=0 edge starts a new frame from IDLE.
- busy=1 in SHIFT and HOLD.

Optional Feature:
- Macro: SPI_CMD_PARITY_EN.
- Defined:
  - A frame is FRAME_W+1 bits; the last bit is even parity over the FRAME_W command bits.
  - On mismatch: no command load, cmd_valid unchanged, overrun unchanged, frame_err=1 for one cycle on the parity-bit edge, go to HOLD.
  - Completion (load/handshake/overrun) occurs on the parity-bit edge.
- Undefined: a frame is exactly FRAME_W bits with no check, and the parity logic is absent.

Test Plan:
- Frame 0b01_0011_0101 (cs low for 10 clocks), result=5'b10110:
  - Response: a=3, b=5, op_code=1, cmd_valid=1 one cycle after the 10th bit.
  - miso sequence 1,0,1,1,0 then 0.
- cmd_valid=1, cmd_ack pulsed one cycle: cmd_valid=0 next cycle, a/b/op_code held.
- cs released after 6 bits: frame_err one-cycle pulse, cmd_valid and a/b/op_code unchanged, state IDLE.
- Two frames with no ack (0x0F5 then 0x2AA): a/b/op_code keep the first frame (op_code=0, a=F, b=5), overrun=1.
  - Repeat with ack on the 2nd completion edge: op_code=2, a=A, b=A, cmd_valid=1, overrun=0.
- rst asserted at bit 4 of a frame: all outputs 0 immediately; the next full frame decodes normally.
- SPI_CMD_PARITY_EN, frame 0x0F5 with parity bit 1 (wrong, the correct bit is 0): frame_err pulse, no cmd_valid.
  - With parity bit 0: cmd_valid=1, a=F, b=5.
